// File: rtl/riscv_crypto_sbox_word_seq.sv
// rtl/riscv_crypto_sbox_word_seq.sv - iterative SubWord/InvSubWord/SM4-tau over one shared S-box
// Optional macro RISCV_CRYPTO_SBOX_WORD_PIPE_EN registers the S-box input byte and op bits.

module riscv_crypto_aes_sm4_sbox (
  input  logic [7:0] operand,
  input  logic       aes,
  input  logic       sm4,
  input  logic       dec,
  output logic [7:0] substituted
);

  // GB/T 32907 table, entry 0 in the most significant byte.
  localparam logic [2047:0] SM4_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the field inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    substituted = 8'h00;
    if (aes && dec)
      substituted = gf_inv(inv_affine(operand));
    else if (aes)
      substituted = affine(gf_inv(operand));
    else if (sm4)
      substituted = SM4_TABLE[{~operand, 3'b000} +: 8];
  end

endmodule

module riscv_crypto_sbox_word_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_aes,
  input  logic        op_dec,
  input  logic [31:0] rs1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef RISCV_CRYPTO_SBOX_WORD_PIPE_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  counter;
  logic [31:0] word;
  logic        aes_q;
  logic        dec_q;
  logic [7:0]  sel_byte;
  logic [7:0]  sbox_x;
  logic        sbox_aes;
  logic        sbox_dec;
  logic [7:0]  sbox_y;

  assign sel_byte = word[{counter[1:0], 3'b000} +: 8];

`ifdef RISCV_CRYPTO_SBOX_WORD_PIPE_EN
  logic [7:0] pipe_byte;
  logic       pipe_aes;
  logic       pipe_dec;
  logic [1:0] wr_idx;

  // The pipe stage trails the counter by one, so the byte landing now is counter-1.
  assign wr_idx   = counter[1:0] - 2'd1;
  assign sbox_x   = pipe_byte;
  assign sbox_aes = pipe_aes;
  assign sbox_dec = pipe_dec;
`else
  assign sbox_x   = sel_byte;
  assign sbox_aes = aes_q;
  assign sbox_dec = dec_q;
`endif

  riscv_crypto_aes_sm4_sbox u_sbox (
    .operand     (sbox_x),
    .aes         (sbox_aes),
    .sm4         (~sbox_aes),
    .dec         (sbox_dec),
    .substituted (sbox_y)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (counter == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      counter <= 3'd0;
      word    <= 32'h0;
      aes_q   <= 1'b0;
      dec_q   <= 1'b0;
      result  <= 32'h0;
`ifdef RISCV_CRYPTO_SBOX_WORD_PIPE_EN
      pipe_byte <= 8'h00;
      pipe_aes  <= 1'b0;
      pipe_dec  <= 1'b0;
`endif
    end else if (flush) begin
      counter <= 3'd0;
`ifdef RISCV_CRYPTO_SBOX_WORD_PIPE_EN
      pipe_byte <= 8'h00;
      pipe_aes  <= 1'b0;
      pipe_dec  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word    <= rs1;
            aes_q   <= op_aes;
            dec_q   <= op_dec;
            counter <= 3'd0;
          end
        end
        BUSY: begin
          counter <= (counter == LAST) ? 3'd0 : counter + 3'd1;
`ifdef RISCV_CRYPTO_SBOX_WORD_PIPE_EN
          if (counter != LAST) begin
            pipe_byte <= sel_byte;
            pipe_aes  <= aes_q;
            pipe_dec  <= dec_q;
          end
          if (counter != 3'd0) result[{wr_idx, 3'b000} +: 8] <= sbox_y;
`else
          result[{counter[1:0], 3'b000} +: 8] <= sbox_y;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/riscv_crypto_sbox_word_seq.md
Name: riscv_crypto_sbox_word_seq

Overview:
Iterative 32-bit SubWord / InvSubWord / SM4-tau unit built around one shared riscv_crypto_aes_sm4_sbox instance.
- Accepts a word with an operation select over a valid/ready handshake.
- Passes the four bytes through the single S-box over consecutive cycles, assembles the result and presents it over a second valid/ready handshake.
- Sits between the scalar crypto FU decode/operand stage and writeback, for area-constrained cores that cannot afford four S-box copies.

Parameters:
- NONE, -, all widths fixed (32-bit word, 8-bit S-box).

Ports:
- g_clk  input  1  clock; all state on rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  unit can accept an operand.
- op_aes  input  1  1 = AES S-box, 0 = SM4 S-box.
- op_dec  input  1  with op_aes=1: 1 = AES inverse S-box; ignored for SM4.
- rs1  input  32  operand word.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  32  substituted word.

Behaviour:
- Reset (g_resetn=0, asynchronous):
  - state=IDLE, counter=0, internal word and result registers = 0.
  - Outputs: in_ready=1, out_valid=0, result=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid at an edge: capture rs1, op_aes and op_dec; counter←0; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - S-box input = captured byte[counter]; byte 0 = bits 7:0, processed first.
  - S-box aes/sm4/dec driven from the captured op bits only. Later changes on op_aes, op_dec or rs1 have no effect.
  - Each edge: result byte[counter] ← S-box output; counter←counter+1.
  - After the edge that writes byte 3: counter wraps to 0; go to DONE.
- DONE:
  - out_valid=1; result stable and held until out_ready.
  - Edge with out_ready=1: go to IDLE. result keeps its last value; out_valid falls.
  - in_ready=0 in DONE. No same-cycle accept.
- Latency: accept at edge E0 → bytes written at E1..E4 → out_valid high from after E4.
  - Minimum occupancy with out_ready tied high: 5 cycles. Next accept no earlier than E6.
- Byte transforms:
  - op_aes=1, op_dec=0: FIPS-197 S-box.
  - op_aes=1, op_dec=1: FIPS-197 inverse S-box.
  - op_aes=0: GB/T 32907 SM4 S-box.
  - Applied per byte independently; no rotation or linear layer.
- flush:
  - Highest priority over in_valid and out_ready. In any state: next edge → IDLE, counter=0, out_valid=0.
  - The result register is not cleared.
  - flush with in_valid in IDLE: the operand is not accepted.
- Reset mid-operation: immediate return to the reset state; the partial word is discarded.
- No X on outputs after reset regardless of input values.

Optional Feature:
- Macro: RISCV_CRYPTO_SBOX_WORD_PIPE_EN.
- Defined: a register stage is inserted on the S-box input byte and op bits, cutting the operand-mux→S-box path.
  - BUSY adds one fill cycle: counter runs 0..4, and result byte k is written at edge E(k+2).
  - out_valid is high from after E5; minimum occupancy 6 cycles.
  - flush and reset also clear the pipeline register.
- Undefined: behaviour as above (4-edge BUSY); no extra flops.

Test Plan:
- AES forward: rs1=0x00010253, op_aes=1, op_dec=0, out_ready=1 → out_valid after E4 (E5 with PIPE_EN), result=0x637C77ED; in_ready low until return to IDLE.
- AES inverse: rs1=0x637C77ED, op_aes=1, op_dec=1 → result=0x00010253.
- SM4: rs1=0xFF000100, op_aes=0, op_dec=1 → op_dec ignored; result=0x48D690D6.
- Backpressure plus operand change: out_ready=0 for 10 cycles after valid, with rs1/op toggled randomly during BUSY/DONE → result constant and out_valid held; one transfer when out_ready=1; in_ready=1 on the next cycle.
- flush at counter=2 of an AES op → IDLE next edge, out_valid never asserted. A subsequent SM4 op on 0x00000000 → result=0xD6D6D6D6.
- Async reset: g_resetn low mid-BUSY, mid-cycle → outputs immediately in_ready=1, out_valid=0, result=0. After release, AES 0x00000000 → 0x63636363.
